multicycle_ctrl: RTL
====================

# multicycle_ctrl

Multi-cycle main controller for the single shared ALU datapath. Sequences fetch, decode, execute, memory and write-back over several cycles per instruction, drives the 3-bit ALUOp code consumed by the ALU control decoder, and stalls on a memory ready handshake. Sits between the instruction register opcode field and the datapath muxes and write enables.

## Interface
- No parameters; all widths fixed.
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-low reset
- instr_op_i  in  6  opcode field of instruction register
- mem_ready_i  in  1  memory completes current read/write this cycle
- pc_write_o  out  1  unconditional PC load
- pc_write_cond_o  out  1  PC load if ALU zero (branch)
- ir_write_o  out  1  instruction register load
- mem_read_o  out  1  memory read request
- mem_write_o  out  1  memory write request
- reg_write_o  out  1  register file write
- alu_op_o  out  3  000 R-type, 001 beq, 010 addi, 011 slti, 100 jal, 101 add (address/PC)
- alu_src_a_o  out  1  0 PC, 1 rs
- alu_src_b_o  out  2  00 rt, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
- pc_src_o  out  2  00 ALU result, 01 ALUOut (branch target), 10 jump target
- reg_dst_o  out  2  00 rt, 01 rd, 10 $31
- mem_to_reg_o  out  2  00 ALUOut, 01 memory data, 10 PC
- illegal_o  out  1  one-cycle pulse: unsupported opcode
- state_o  out  4  current state encoding

## Operation
- Opcodes: R=0, j=2, jal=3, beq=4, addi=8, slti=10, lw=35, sw=43; any other is illegal.
- Moore outputs decoded from state; only pc_write_o/ir_write_o in FETCH and nothing else depend on mem_ready_i. Outputs not listed for a state are 0.
- Opcode latched into internal op_q in DECODE; later states use op_q, not instr_op_i.
- States (state_o value):
- FETCH(0): mem_read=1, alu_src_a=0, alu_src_b=01, alu_op=101, pc_src=00; if mem_ready_i: ir_write=pc_write=1, go DECODE; else stay.
- DECODE(1): alu_src_a=0, alu_src_b=11, alu_op=101 (branch target into ALUOut). R->EXEC_R; addi/slti->EXEC_I; lw/sw->MEM_ADDR; beq->BRANCH; j/jal->JUMP; illegal: illegal_o=1, ->FETCH.
- EXEC_R(2): alu_src_a=1, alu_src_b=00, alu_op=000 -> WB_ALU.
- EXEC_I(3): alu_src_a=1, alu_src_b=10, alu_op=010 (addi) or 011 (slti) -> WB_ALU.
- MEM_ADDR(4): alu_src_a=1, alu_src_b=10, alu_op=101 -> MEM_RD (lw) or MEM_WR (sw).
- MEM_RD(5): mem_read=1; mem_ready_i -> WB_MEM, else stay.
- MEM_WR(6): mem_write=1; mem_ready_i -> FETCH, else stay.
- WB_MEM(7): reg_write=1, reg_dst=00, mem_to_reg=01 -> FETCH.
- WB_ALU(8): reg_write=1, mem_to_reg=00, reg_dst=01 if op_q=R else 00 -> FETCH.
- BRANCH(9): alu_src_a=1, alu_src_b=00, alu_op=001, pc_write_cond=1, pc_src=01 -> FETCH.
- JUMP(10): pc_write=1, pc_src=10; jal additionally reg_write=1, reg_dst=10, mem_to_reg=10, alu_op=100 -> FETCH.
- Encodings 11-15 unreachable; if entered, outputs 0, next state FETCH.

## Timing
- rst_i low: state=FETCH, op_q=0 immediately (async); all outputs forced 0 while rst_i low, state_o=0. First active cycle after release is FETCH with mem_read_o=1.
- Reset mid-instruction aborts it; no strobe asserted after rst_i falls.
- Cycles with zero-wait memory: R/addi/slti 4, lw 5, sw 4, beq 3, j/jal 3, illegal 2.
- Each memory wait cycle adds one cycle; request outputs held stable while waiting.
- mem_ready_i ignored in states other than FETCH, MEM_RD, MEM_WR.
- illegal_o high exactly one cycle (DECODE), never with any write strobe.

## Test plan
- Reset: rst_i low mid-MEM_WR -> mem_write_o drops at once, state_o=0; after release state_o=0, mem_read_o=1.
- R-type (op 0), mem_ready_i=1 -> state_o 0,1,2,8,0; alu_op_o=000 in state 2; reg_write_o=1, reg_dst_o=01 in state 8.
- lw (op 35), mem_ready_i low 2 cycles in MEM_RD -> states 0,1,4,5,5,5,7,0; mem_read_o=1 throughout 5; mem_to_reg_o=01 in 7.
- beq (op 4) -> states 0,1,9,0; alu_op_o=001, pc_write_cond_o=1, pc_src_o=01 in state 9; jal (op 3) -> state 10 with reg_dst_o=10, mem_to_reg_o=10, pc_write_o=1.
- Fetch stall: mem_ready_i low 3 cycles in FETCH -> ir_write_o/pc_write_o 0 until ready, then both 1 for one cycle.
- Illegal op 63 -> states 0,1,0; illegal_o=1 only in state 1, all write strobes 0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multi-cycle main controller: sequences fetch/decode/execute/memory/write-back
// for the shared-ALU datapath and stalls on the memory ready handshake.
module multicycle_ctrl (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] instr_op_i,
  input  logic       mem_ready_i,
  output logic       pc_write_o,
  output logic       pc_write_cond_o,
  output logic       ir_write_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       reg_write_o,
  output logic [2:0] alu_op_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] pc_src_o,
  output logic [1:0] reg_dst_o,
  output logic [1:0] mem_to_reg_o,
  output logic       illegal_o,
  output logic [3:0] state_o
);

  localparam int unsigned OP_W = 6;

  localparam logic [OP_W-1:0] OP_R    = OP_W'(0);
  localparam logic [OP_W-1:0] OP_J    = OP_W'(2);
  localparam logic [OP_W-1:0] OP_JAL  = OP_W'(3);
  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(8);
  localparam logic [OP_W-1:0] OP_SLTI = OP_W'(10);
  localparam logic [OP_W-1:0] OP_LW   = OP_W'(35);
  localparam logic [OP_W-1:0] OP_SW   = OP_W'(43);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    EXEC_R   = 4'd2,
    EXEC_I   = 4'd3,
    MEM_ADDR = 4'd4,
    MEM_RD   = 4'd5,
    MEM_WR   = 4'd6,
    WB_MEM   = 4'd7,
    WB_ALU   = 4'd8,
    BRANCH   = 4'd9,
    JUMP     = 4'd10
  } state_t;

  state_t          state_q, state_d;
  logic [OP_W-1:0] op_q;

  logic       pc_write_c, pc_write_cond_c, ir_write_c, mem_read_c, mem_write_c;
  logic       reg_write_c, alu_src_a_c, illegal_c;
  logic [2:0] alu_op_c;
  logic [1:0] alu_src_b_c, pc_src_c, reg_dst_c, mem_to_reg_c;

  // State and opcode registers; the opcode is captured as DECODE retires.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= FETCH;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == DECODE) op_q <= instr_op_i;
    end
  end

  // Next-state and Moore output decode.
  always_comb begin
    state_d         = state_q;
    pc_write_c      = 1'b0;
    pc_write_cond_c = 1'b0;
    ir_write_c      = 1'b0;
    mem_read_c      = 1'b0;
    mem_write_c     = 1'b0;
    reg_write_c     = 1'b0;
    alu_src_a_c     = 1'b0;
    illegal_c       = 1'b0;
    alu_op_c        = 3'b000;
    alu_src_b_c     = 2'b00;
    pc_src_c        = 2'b00;
    reg_dst_c       = 2'b00;
    mem_to_reg_c    = 2'b00;
    case (state_q)
      FETCH: begin
        mem_read_c  = 1'b1;
        alu_src_b_c = 2'b01;
        alu_op_c    = 3'b101;
        if (mem_ready_i) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_d    = DECODE;
        end
      end
      DECODE: begin
        alu_src_b_c = 2'b11;
        alu_op_c    = 3'b101;
        case (instr_op_i)
          OP_R:             state_d = EXEC_R;
          OP_ADDI, OP_SLTI: state_d = EXEC_I;
          OP_LW, OP_SW:     state_d = MEM_ADDR;
          OP_BEQ:           state_d = BRANCH;
          OP_J, OP_JAL:     state_d = JUMP;
          default: begin
            illegal_c = 1'b1;
            state_d   = FETCH;
          end
        endcase
      end
      EXEC_R: begin
        alu_src_a_c = 1'b1;
        state_d     = WB_ALU;
      end
      EXEC_I: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'b10;
        alu_op_c    = (op_q == OP_SLTI) ? 3'b011 : 3'b010;
        state_d     = WB_ALU;
      end
      MEM_ADDR: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'b10;
        alu_op_c    = 3'b101;
        state_d     = (op_q == OP_LW) ? MEM_RD : MEM_WR;
      end
      MEM_RD: begin
        mem_read_c = 1'b1;
        if (mem_ready_i) state_d = WB_MEM;
      end
      MEM_WR: begin
        mem_write_c = 1'b1;
        if (mem_ready_i) state_d = FETCH;
      end
      WB_MEM: begin
        reg_write_c  = 1'b1;
        mem_to_reg_c = 2'b01;
        state_d      = FETCH;
      end
      WB_ALU: begin
        reg_write_c = 1'b1;
        reg_dst_c   = (op_q == OP_R) ? 2'b01 : 2'b00;
        state_d     = FETCH;
      end
      BRANCH: begin
        alu_src_a_c     = 1'b1;
        alu_op_c        = 3'b001;
        pc_write_cond_c = 1'b1;
        pc_src_c        = 2'b01;
        state_d         = FETCH;
      end
      JUMP: begin
        pc_write_c = 1'b1;
        pc_src_c   = 2'b10;
        if (op_q == OP_JAL) begin
          reg_write_c  = 1'b1;
          reg_dst_c    = 2'b10;
          mem_to_reg_c = 2'b10;
          alu_op_c     = 3'b100;
        end
        state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  // Outputs are held low for as long as reset is asserted.
  assign pc_write_o      = rst_i & pc_write_c;
  assign pc_write_cond_o = rst_i & pc_write_cond_c;
  assign ir_write_o      = rst_i & ir_write_c;
  assign mem_read_o      = rst_i & mem_read_c;
  assign mem_write_o     = rst_i & mem_write_c;
  assign reg_write_o     = rst_i & reg_write_c;
  assign alu_src_a_o     = rst_i & alu_src_a_c;
  assign illegal_o       = rst_i & illegal_c;
  assign alu_op_o        = {3{rst_i}} & alu_op_c;
  assign alu_src_b_o     = {2{rst_i}} & alu_src_b_c;
  assign pc_src_o        = {2{rst_i}} & pc_src_c;
  assign reg_dst_o       = {2{rst_i}} & reg_dst_c;
  assign mem_to_reg_o    = {2{rst_i}} & mem_to_reg_c;
  assign state_o         = state_q;

endmodule
